// File: rtl/approx_mul_err_sweeper_pkg.sv
// Shared types and width helpers for the approximate-multiplier error sweeper.
// Statistic widths are derived from the operand width so no count can overflow.
package approx_mul_sweep_pkg;

  localparam int W_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  // Vector-count width: must hold 2**(2w), the full vector count.
  function automatic int calc_cw(input int w);
    return 2 * w + 1;
  endfunction

  // Error-sum width: must hold 2**(2w) * (2**(2w) - 1).
  function automatic int calc_sw(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/approx_mul_err_sweeper_mul_err_unit.sv
// Per-vector error evaluation: absolute product error, nonzero flag and
// threshold violation flag. Purely combinational, used in pipeline stage 2.
module mul_err_unit #(
  parameter int PW = 4
) (
  input  logic [PW-1:0] i_p,
  input  logic [PW-1:0] i_exact,
  input  logic [PW-1:0] i_et,
  output logic [PW-1:0] o_e,
  output logic          o_nz,
  output logic          o_viol
);

  // Subtract in the order that cannot underflow.
  assign o_e    = (i_p >= i_exact) ? (i_p - i_exact) : (i_exact - i_p);
  assign o_nz   = |o_e;
  assign o_viol = (o_e > i_et);

endmodule

// File: rtl/approx_mul_err_sweeper.sv
// Exhaustive sweep controller for an external combinational approximate
// multiplier; accumulates max/count/violation/sum error statistics.
module approx_mul_err_sweeper
  import approx_mul_sweep_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2*W-1:0]         et,
  output logic [W-1:0]           dut_a,
  output logic [W-1:0]           dut_b,
  input  logic [2*W-1:0]         dut_p,
  output logic                   busy,
  output logic                   done,
  output logic [2*W-1:0]         max_err,
  output logic [calc_cw(W)-1:0]  err_cnt,
  output logic [calc_cw(W)-1:0]  viol_cnt,
  output logic [calc_sw(W)-1:0]  err_sum,
  output logic                   pass
);

  localparam int NV = 2 ** (2 * W);
  localparam int CW = calc_cw(W);
  localparam int SW = calc_sw(W);
  localparam int PW = 2 * W;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_FIN   = FIN;

  localparam logic [PW-1:0] LAST_VEC = PW'(NV - 1);

  // NOTE: assertion is asynchronous, release is re-timed to clk so every
  // flop leaves reset on the same edge regardless of when rst_n rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [1:0]    r_state;
  logic [PW-1:0] r_vec;
  logic [PW-1:0] r_et;
  logic          r_s1_valid;
  logic [PW-1:0] r_s1_p;
  logic [PW-1:0] r_s1_exact;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [PW-1:0] r_max_err;
  logic [CW-1:0] r_err_cnt;
  logic [CW-1:0] r_viol_cnt;
  logic [SW-1:0] r_err_sum;

  logic [PW-1:0] w_exact;
  logic [PW-1:0] w_e;
  logic          w_nz;
  logic          w_viol;

  assign dut_a   = r_vec[PW-1:W];
  assign dut_b   = r_vec[W-1:0];
  assign w_exact = PW'(dut_a) * PW'(dut_b);

  mul_err_unit #(.PW(PW)) u_err (
    .i_p     (r_s1_p),
    .i_exact (r_s1_exact),
    .i_et    (r_et),
    .o_e     (w_e),
    .o_nz    (w_nz),
    .o_viol  (w_viol)
  );

  // NOTE: all state updates use non-blocking assignment so stage 2 sees the
  // stage-1 values captured on the previous edge, not this one.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= S_IDLE;
      r_vec      <= '0;
      r_et       <= '0;
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_exact <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_max_err  <= '0;
      r_err_cnt  <= '0;
      r_viol_cnt <= '0;
      r_err_sum  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_s1_valid <= 1'b0;

      if (r_s1_valid) begin
        if (w_e > r_max_err) r_max_err <= w_e;
        r_err_cnt  <= r_err_cnt + CW'(w_nz);
        r_viol_cnt <= r_viol_cnt + CW'(w_viol);
        r_err_sum  <= r_err_sum + SW'(w_e);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_et       <= et;
            r_vec      <= '0;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_max_err  <= '0;
            r_err_cnt  <= '0;
            r_viol_cnt <= '0;
            r_err_sum  <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_s1_p     <= dut_p;
            r_s1_exact <= w_exact;
            r_s1_valid <= 1'b1;
            r_vec      <= r_vec + PW'(1);
            if (r_vec == LAST_VEC) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          // Stage 2 has fully drained, so viol_cnt is final here.
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_viol_cnt == '0);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign max_err  = r_max_err;
  assign err_cnt  = r_err_cnt;
  assign viol_cnt = r_viol_cnt;
  assign err_sum  = r_err_sum;

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Self-checking bench: behavioural multiplier stand-ins and a loop-based
// statistics model, with scenario tasks for sweep, abort and reset cases.
module tb_approx_mul_err_sweeper;

  localparam int W  = 2;
  localparam int NV = 16;
  localparam int CW = 5;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    et = '0;
  logic [1:0]    dut_a, dut_b;
  logic [3:0]    dut_p;
  logic          busy, done, pass;
  logic [3:0]    max_err;
  logic [CW-1:0] err_cnt, viol_cnt;
  logic [SW-1:0] err_sum;

  int checks = 0;
  int errors = 0;

  // 0 = exact multiplier, 1 = stuck-at-zero, 2 = lookup table
  int         mode = 0;
  logic [3:0] lut [NV];

  int exp_max, exp_cnt, exp_viol, exp_sum;
  logic exp_pass;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      0:       dut_p = 4'(dut_a) * 4'(dut_b);
      1:       dut_p = 4'd0;
      default: dut_p = lut[{dut_a, dut_b}];
    endcase
  end

  approx_mul_err_sweeper #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .et       (et),
    .dut_a    (dut_a),
    .dut_b    (dut_b),
    .dut_p    (dut_p),
    .busy     (busy),
    .done     (done),
    .max_err  (max_err),
    .err_cnt  (err_cnt),
    .viol_cnt (viol_cnt),
    .err_sum  (err_sum),
    .pass     (pass)
  );

  function automatic int approx_of(input int a, input int b);
    if (mode == 0) return a * b;
    if (mode == 1) return 0;
    return int'(lut[a * 4 + b]);
  endfunction

  task automatic compute_expected(input int thr);
    int e;
    exp_max = 0; exp_cnt = 0; exp_viol = 0; exp_sum = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        e = approx_of(a, b) - a * b;
        if (e < 0) e = -e;
        if (e > exp_max) exp_max = e;
        if (e != 0) exp_cnt++;
        if (e > thr) exp_viol++;
        exp_sum += e;
      end
    end
    exp_pass = (exp_viol == 0);
  endtask

  // One sweep; abort_at < 0 runs to completion, restart_at re-pulses start.
  task automatic do_sweep(input string name, input logic [3:0] et_v,
                          input int restart_at, input int abort_at);
    int done_cnt, done_cyc, busy_len, seq_bad;
    done_cnt = 0; done_cyc = -1; busy_len = 0; seq_bad = 0;
    compute_expected(int'(et_v));
    @(negedge clk);
    start = 1'b1;
    et    = et_v;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (busy) busy_len++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc < NV && (abort_at < 0 || cyc <= abort_at))
        if (dut_a !== 2'(cyc / 4) || dut_b !== 2'(cyc % 4)) seq_bad++;
      start = (cyc == restart_at);
      abort = (cyc == abort_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;

    checks++;
    if (seq_bad !== 0) begin
      errors++; $display("FAIL %s operand_seq bad_pairs=%0d required=0", name, seq_bad);
    end
    if (abort_at < 0) begin
      checks++;
      if (done_cnt !== 1 || done_cyc !== 18) begin
        errors++; $display("FAIL %s done_timing pulses=%0d cycle=%0d required 1 at 18", name, done_cnt, done_cyc);
      end
      checks++;
      if (busy_len !== 18) begin
        errors++; $display("FAIL %s busy_len got %0d required 18", name, busy_len);
      end
      checks++;
      if (max_err !== 4'(exp_max)) begin
        errors++; $display("FAIL %s max_err got %0d required %0d", name, max_err, exp_max);
      end
      checks++;
      if (err_cnt !== CW'(exp_cnt)) begin
        errors++; $display("FAIL %s err_cnt got %0d required %0d", name, err_cnt, exp_cnt);
      end
      checks++;
      if (viol_cnt !== CW'(exp_viol)) begin
        errors++; $display("FAIL %s viol_cnt got %0d required %0d", name, viol_cnt, exp_viol);
      end
      checks++;
      if (err_sum !== SW'(exp_sum)) begin
        errors++; $display("FAIL %s err_sum got %0d required %0d", name, err_sum, exp_sum);
      end
      checks++;
      if (pass !== exp_pass) begin
        errors++; $display("FAIL %s pass got %0b required %0b", name, pass, exp_pass);
      end
    end else begin
      checks++;
      if (done_cnt !== 0) begin
        errors++; $display("FAIL %s abort_done pulses=%0d required 0", name, done_cnt);
      end
      checks++;
      if (busy_len !== abort_at + 1) begin
        errors++; $display("FAIL %s abort_busy_len got %0d required %0d", name, busy_len, abort_at + 1);
      end
      checks++;
      if (pass !== 1'b0) begin
        errors++; $display("FAIL %s abort_pass got %0b required 0", name, pass);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, pass, dut_a, dut_b, max_err, err_cnt, viol_cnt, err_sum} !== '0) begin
      errors++;
      $display("FAIL %s outputs busy=%0b done=%0b pass=%0b a=%0d b=%0d max=%0d cnt=%0d viol=%0d sum=%0d required all 0",
               name, busy, done, pass, dut_a, dut_b, max_err, err_cnt, viol_cnt, err_sum);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_all_zero("reset_released");
  endtask

  task automatic test_exact();
    mode = 0;
    do_sweep("exact", 4'd0, -1, -1);
  endtask

  task automatic test_stuck_zero();
    mode = 1;
    do_sweep("stuck0_et4", 4'd4, -1, -1);
    do_sweep("stuck0_et15", 4'd15, -1, -1);
  endtask

  task automatic test_random_lut();
    for (int i = 0; i < 6; i++) begin
      mode = 2;
      for (int k = 0; k < NV; k++)
        lut[k] = ($urandom_range(0, 1) == 0) ? 4'((k / 4) * (k % 4)) : 4'($urandom_range(0, 15));
      do_sweep($sformatf("rand_lut%0d", i), 4'($urandom_range(0, 15)), -1, -1);
    end
  endtask

  task automatic test_restart_ignored();
    mode = 1;
    do_sweep("restart_ignored", 4'd4, 5, -1);
  endtask

  task automatic test_abort();
    mode = 1;
    do_sweep("abort", 4'd0, -1, 8);
    mode = 0;
    do_sweep("after_abort", 4'd0, -1, -1);
  endtask

  task automatic test_reset_mid();
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    et    = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_sweep");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_all_zero("reset_mid_idle");
    mode = 2;
    for (int k = 0; k < NV; k++) lut[k] = 4'($urandom_range(0, 15));
    do_sweep("after_reset", 4'd3, -1, -1);
  endtask

  task automatic test_back_to_back();
    mode = 1;
    do_sweep("b2b_first", 4'd1, -1, -1);
    mode = 0;
    do_sweep("b2b_second", 4'd0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_stuck_zero();
    test_random_lut();
    test_restart_ignored();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
